// File: rtl/led_pwm_blink_mmio_if.sv
// CPU memory-bus bundle for the LED conditioner's single control word.
//   memAddress   : byte address from the CPU
//   memWriteData : write data, big-endian lanes
//   memWrite     : write strobe
//   byteMask     : lane enables, [0]->[31:24] .. [3]->[7:0]
//   memReadData  : registered read data, 0 when the address is not ours
interface led_pwm_blink_mmio_if;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWrite;
  logic [3:0]  byteMask;
  logic [31:0] memReadData;

  modport master (output memAddress, memWriteData, memWrite, byteMask,
                  input  memReadData);
  modport slave  (input  memAddress, memWriteData, memWrite, byteMask,
                  output memReadData);
endinterface

// File: rtl/led_pwm_blink_mmio.sv
// LED conditioner sitting behind the GPIO block. Each active-low request is
// dimmed by an 8-bit PWM compare and gated by a shared blink phase, then
// registered onto the board pin.
//   clk, rst_n          : clock, async active-low reset
//   bus (slave)         : CTRL word access, see led_pwm_blink_mmio_if
//   ledr_n_in/ledg_n_in : GPIO requests, 0 = on
//   ledr_n/ledg_n       : LED pins, 0 = lit
// CTRL: [7:0] DUTY_R, [15:8] DUTY_G, [23:16] BLINK_HALF, [24] PWM_EN.

// One LED channel: compare, gate and register.
module led_pwm_blink_mmio_chan (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_n,
  input  logic       phase,
  input  logic       pwm_en,
  input  logic [7:0] duty,
  input  logic [7:0] pwm_cnt,
  output logic       led_n
);
  logic lit;
  // DUTY=0 never lights; DUTY=255 misses only pwm_cnt=255.
  assign lit = ~req_n & phase & (~pwm_en | (pwm_cnt < duty));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) led_n <= 1'b1;
    else        led_n <= ~lit;
endmodule

module led_pwm_blink_mmio #(
  parameter logic [31:0] BASE_MEMORY = 32'hFFFF_FFE0,
  parameter logic [31:0] TOP_MEMORY  = 32'hFFFF_FFE3,
  parameter int          PRESCALE    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_pwm_blink_mmio_if.slave  bus,
  input  logic                 ledr_n_in,
  input  logic                 ledg_n_in,
  output logic                 ledr_n,
  output logic                 ledg_n
);
  localparam int NUM_LANES = 2;
  localparam int PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [24:0]   ctrl_q;
  logic [PW-1:0] pre_cnt;
  logic [7:0]    pwm_cnt, blink_cnt;
  logic          blink_phase;
  logic          in_range, wr_en, restart, tick, period_end;
  logic [7:0]    blink_half;

  assign in_range   = (bus.memAddress >= BASE_MEMORY) && (bus.memAddress <= TOP_MEMORY);
  assign wr_en      = in_range & bus.memWrite;
  // A write touching byte lane 2 restarts the whole timebase from an ON phase.
  assign restart    = wr_en & bus.byteMask[2];
  assign tick       = (pre_cnt == PRE_LAST);
  assign period_end = tick & (pwm_cnt == 8'hFF);
  assign blink_half = ctrl_q[23:16];

  // Reserved write bits are dropped on the floor.
  logic unused_wdata;
  assign unused_wdata = &{1'b0, bus.memWriteData[31:25]};

  // CTRL register, big-endian lanes; reserved bits never stored.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ctrl_q <= '0;
    else if (wr_en) begin
      if (bus.byteMask[0]) ctrl_q[24]    <= bus.memWriteData[24];
      if (bus.byteMask[1]) ctrl_q[23:16] <= bus.memWriteData[23:16];
      if (bus.byteMask[2]) ctrl_q[15:8]  <= bus.memWriteData[15:8];
      if (bus.byteMask[3]) ctrl_q[7:0]   <= bus.memWriteData[7:0];
    end

  // Read returns pre-write contents; 0 out of range so the bus can OR slaves.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)        bus.memReadData <= '0;
    else if (in_range) bus.memReadData <= {7'b0, ctrl_q};
    else               bus.memReadData <= '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       pre_cnt <= '0;
    else if (restart) pre_cnt <= '0;
    else if (tick)    pre_cnt <= '0;
    else              pre_cnt <= pre_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)       pwm_cnt <= '0;
    else if (restart) pwm_cnt <= '0;
    else if (tick)    pwm_cnt <= pwm_cnt + 8'd1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (restart || blink_half == 8'd0) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (period_end) begin
      if (blink_cnt == blink_half - 8'd1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + 8'd1;
      end
    end

  // Lane 0 = red, lane 1 = green.
  logic [NUM_LANES-1:0]      req_n, led_q;
  logic [NUM_LANES-1:0][7:0] duty;
  assign req_n = {ledg_n_in, ledr_n_in};
  assign duty  = {ctrl_q[15:8], ctrl_q[7:0]};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_chan
    led_pwm_blink_mmio_chan u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_n   (req_n[i]),
      .phase   (blink_phase),
      .pwm_en  (ctrl_q[24]),
      .duty    (duty[i]),
      .pwm_cnt (pwm_cnt),
      .led_n   (led_q[i])
    );
  end

  assign ledr_n = led_q[0];
  assign ledg_n = led_q[1];
endmodule

// File: tb/tb_led_pwm_blink_mmio.sv
// Bench for led_pwm_blink_mmio. Each driven cycle pushes the expected read
// data and LED pins for the next sample; the next negedge pops and compares.
// LED expectations use closed forms in k = cycles since the last timebase
// restart (PRESCALE=1): pwm_cnt = k%256, blink ON when (k/256/N) is even.
module tb_led_pwm_blink_mmio;
  localparam logic [31:0] BASE = 32'hFFFF_FFE0;
  localparam logic [31:0] TOP  = 32'hFFFF_FFE3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ledr_n_in = 1'b1, ledg_n_in = 1'b1;
  logic ledr_n, ledg_n;

  led_pwm_blink_mmio_if bus ();

  led_pwm_blink_mmio #(.BASE_MEMORY(BASE), .TOP_MEMORY(TOP), .PRESCALE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ledr_n_in (ledr_n_in),
    .ledg_n_in (ledg_n_in),
    .ledr_n    (ledr_n),
    .ledg_n    (ledg_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        r_n;
    logic        g_n;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0;
  logic [31:0] ctrl_m;
  int          k;
  string       tag;
  logic        req_r = 1'b1, req_g = 1'b1;

  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", t, got, want);
    end
  endtask

  function automatic logic lit_f(input logic req_n, input logic [7:0] duty);
    logic [7:0] p;
    int         n;
    logic       ph;
    p  = 8'(k % 256);
    n  = int'(ctrl_m[23:16]);
    ph = (n == 0) ? 1'b1 : (((k / 256) / n) % 2 == 0);
    return ~req_n & ph & (~ctrl_m[24] | (p < duty));
  endfunction

  task automatic drain();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.tag, "/rd"},     bus.memReadData,  e.rd);
      chk({e.tag, "/ledr_n"}, {31'b0, ledr_n}, {31'b0, e.r_n});
      chk({e.tag, "/ledg_n"}, {31'b0, ledg_n}, {31'b0, e.g_n});
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic we, input logic [3:0] m);
    exp_t e;
    logic in_rng;
    bus.memAddress   = a;
    bus.memWriteData = d;
    bus.memWrite     = we;
    bus.byteMask     = m;
    ledr_n_in        = req_r;
    ledg_n_in        = req_g;
    in_rng = (a >= BASE) && (a <= TOP);
    e.tag  = tag;
    e.rd   = in_rng ? ctrl_m : 32'h0;
    e.r_n  = ~lit_f(req_r, ctrl_m[7:0]);
    e.g_n  = ~lit_f(req_g, ctrl_m[15:8]);
    sb.push_back(e);
    if (in_rng && we) begin
      for (int i = 0; i < 4; i++)
        if (m[i]) ctrl_m[31-8*i -: 8] = d[31-8*i -: 8];
      ctrl_m &= 32'h01FF_FFFF;
    end
    k = (in_rng && we && m[2]) ? 0 : k + 1;
  endtask

  task automatic cyc(input logic [31:0] a, input logic [31:0] d,
                     input logic we, input logic [3:0] m);
    @(negedge clk);
    drain();
    drive(a, d, we, m);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(32'h0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic release_rst();
    rst_n  = 1'b1;
    ctrl_m = '0;
    k      = 0;
    drive(32'h0, 32'h0, 1'b0, 4'h0);
  endtask

  initial begin
    bus.memAddress = '0; bus.memWriteData = '0; bus.memWrite = 1'b0; bus.byteMask = '0;
    ctrl_m = '0; k = 0;

    // Power-on reset
    #1 rst_n = 1'b0;
    #2;
    chk("reset/ledr_n", {31'b0, ledr_n}, 32'd1);
    chk("reset/ledg_n", {31'b0, ledg_n}, 32'd1);
    chk("reset/rd",     bus.memReadData, 32'h0);
    repeat (2) @(negedge clk);
    release_rst();
    tag = "idle0"; idle(4);

    // GPIO passthrough with CTRL=0
    tag = "pass"; req_r = 1'b0; idle(4);
    req_r = 1'b1; idle(2);

    // Mid-run async reset with both LEDs lit
    tag = "rst_mid"; req_r = 1'b0; req_g = 1'b0;
    cyc(BASE, 32'h0000_1234, 1'b1, 4'hF);
    idle(3);
    @(negedge clk);
    drain();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async/ledr_n", {31'b0, ledr_n}, 32'd1);
    chk("rst_async/ledg_n", {31'b0, ledg_n}, 32'd1);
    chk("rst_async/rd",     bus.memReadData, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_hold/ledr_n", {31'b0, ledr_n}, 32'd1);
    chk("rst_hold/rd",     bus.memReadData, 32'h0);
    release_rst();
    tag = "rst_read"; cyc(BASE, 32'h0, 1'b0, 4'h0); idle(2);

    // Byte-lane masking
    tag = "mask_b0"; cyc(BASE, 32'hFFFF_FFFF, 1'b1, 4'b0001); cyc(BASE, 32'h0, 1'b0, 4'h0);
    tag = "mask_b3"; cyc(BASE, 32'h0000_00AA, 1'b1, 4'b1000); cyc(BASE, 32'h0, 1'b0, 4'h0);
    tag = "mask_pwm"; idle(300);

    // Address decode and read-during-write
    tag = "dec_hi";  cyc(32'hFFFF_FFE4, 32'hFFFF_FFFF, 1'b1, 4'hF);
    tag = "dec_lo";  cyc(32'hFFFF_FFDF, 32'hFFFF_FFFF, 1'b1, 4'hF);
    tag = "dec_rd";  cyc(BASE, 32'h0, 1'b0, 4'h0); cyc(TOP, 32'h0, 1'b0, 4'h0);
    tag = "rdw_old"; cyc(BASE + 32'd2, 32'h0000_0055, 1'b1, 4'hF);
    tag = "rdw_new"; cyc(BASE, 32'h0, 1'b0, 4'h0);
    idle(2);

    // PWM 50% red / 25% green, then the duty extremes
    tag = "pwm";     cyc(BASE, 32'h0100_4080, 1'b1, 4'hF); idle(520);
    tag = "duty0";   cyc(BASE, 32'h0000_0000, 1'b1, 4'b1000); idle(260);
    tag = "duty255"; cyc(BASE, 32'h0000_00FF, 1'b1, 4'b1000); idle(260);

    // Blink N=2: ON k=0..511, dark from 512; restart mid-dark
    tag = "blink";   cyc(BASE, 32'h0102_FFFF, 1'b1, 4'hF); idle(600);
    tag = "blink_rs"; cyc(BASE, 32'h0000_FF00, 1'b1, 4'b0100);
    tag = "blink_on"; idle(40);

    @(negedge clk);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
